// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding and framing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 87;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign o_count = r_wptr - r_rptr;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  assign w_pop  = i_pop && !o_empty;
  // A write into a full FIFO still lands when the head leaves on the same edge.
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small FIFO; frames go out back-to-back, LSB first.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          TXD,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BW = $clog2(UART_DATA_BITS);

  tx_state_e                 r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [BW-1:0]             r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_txd;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_pop;
  logic                      w_bit_end;
  logic [UART_DATA_BITS-1:0] w_head;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (tx_valid),
    .i_wdata (tx_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  // Pop when idle, or on the last stop cycle so the next start follows with no gap.
  assign w_pop     = !w_empty && ((r_state == StIdle) || ((r_state == StStop) && w_bit_end));
  assign tx_ready  = !w_full;
  assign tx_busy   = (r_state != StIdle) || !w_empty;
  assign TXD       = r_txd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_head;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= StStart;
          end
        end
        StStart: begin
          r_txd <= 1'b0;
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= StData;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StData: begin
          r_txd <= r_shift[0];
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit_idx == BW'(UART_DATA_BITS - 1)) begin
              r_state <= StStop;
            end else begin
              r_bit_idx <= r_bit_idx + BW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StStop: begin
          r_txd <= 1'b1;
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_shift   <= w_head;
              r_bit_idx <= '0;
              r_state   <= StStart;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: accepted bytes are queued; a serial receiver model decodes TXD and compares.
module tb_uart_tx_fifo;

  localparam int CPB   = 87;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       TXD;
  logic       tx_busy;
  logic [2:0] fifo_count;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         max_cnt = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  bit         aborted = 1'b0;
  logic [7:0] rx_b;
  logic       rx_s;
  logic       rx_p;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .TXD        (TXD),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (resetn === 1'b1 && int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_err++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", budget);
    end
    repeat (20) tick();
  endtask

  // Serial receiver: detect start, sample each bit at its centre, compare against the queue.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && TXD === 1'b0) begin
        starts.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        rx_s = TXD;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_b[i] = TXD;
        end
        repeat (CPB) @(negedge clk);
        rx_p = TXD;
        if (aborted) begin
          aborted = 1'b0;
        end else begin
          check("start_bit", {31'd0, rx_s}, 32'd0);
          check("stop_bit", {31'd0, rx_p}, 32'd1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_byte: got 0x%0h, expected no frame", rx_b);
          end else begin
            check("rx_byte", {24'd0, rx_b}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    int n0;
    logic lvl;

    // Reset state
    repeat (3) tick();
    check("rst_txd", {31'd0, TXD}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    resetn = 1'b1;
    repeat (5) tick();

    // 0x3F: latency and frame length
    tx_valid = 1'b1;
    tx_data  = 8'h3F;
    @(posedge clk);
    exp_q.push_back(8'h3F);
    #1 tx_valid = 1'b0;
    check("push_count", {29'd0, fifo_count}, 32'd1);
    check("push_busy", {31'd0, tx_busy}, 32'd1);
    check("lat_edge0", {31'd0, TXD}, 32'd1);
    tick();
    check("lat_edge1", {31'd0, TXD}, 32'd1);
    tick();
    check("lat_edge2", {31'd0, TXD}, 32'd0);
    repeat (782) tick();
    check("bit7_3f", {31'd0, TXD}, 32'd0);
    tick();
    check("stop_rise", {31'd0, TXD}, 32'd1);
    repeat (87) tick();
    check("post_txd", {31'd0, TXD}, 32'd1);
    check("post_busy", {31'd0, tx_busy}, 32'd0);
    check("post_count", {29'd0, fifo_count}, 32'd0);
    wait_idle(2000);

    // 0x55: every level held exactly CPB clocks
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    @(posedge clk);
    exp_q.push_back(8'h55);
    #1 tx_valid = 1'b0;
    n = 0;
    while (TXD !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    for (int i = 0; i < 9; i++) begin
      lvl = TXD;
      check("lvl_55", {31'd0, lvl}, 32'(i % 2));
      n = 0;
      while (TXD === lvl && n < 200) begin
        tick();
        n++;
      end
      check("run_55", 32'(n), 32'(CPB));
    end
    wait_idle(2000);

    // Back-to-back 0x01..0x05, then 0x06 held while full until the pop edge
    starts.delete();
    max_cnt  = 0;
    tx_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tx_data = 8'(k);
      @(posedge clk);
      exp_q.push_back(8'(k));
      #1;
    end
    check("b2b_ready_full", {31'd0, tx_ready}, 32'd0);
    check("b2b_count_full", {29'd0, fifo_count}, 32'd4);
    tx_data = 8'h06;
    repeat (866) tick();
    check("b2b_hold_ready", {31'd0, tx_ready}, 32'd0);
    check("b2b_hold_count", {29'd0, fifo_count}, 32'd4);
    @(posedge clk);
    exp_q.push_back(8'h06);
    #1 tx_valid = 1'b0;
    check("b2b_pp_count", {29'd0, fifo_count}, 32'd4);
    wait_idle(8000);
    check("b2b_max_count", 32'(max_cnt), 32'd4);
    check("b2b_frames", 32'(starts.size()), 32'd6);
    for (int i = 1; i < starts.size(); i++) check("b2b_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME));

    // Simultaneous push/pop on the last stop cycle with one byte stored
    starts.delete();
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    @(posedge clk);
    exp_q.push_back(8'hC3);
    #1 tx_data = 8'h3C;
    @(posedge clk);
    exp_q.push_back(8'h3C);
    #1 tx_valid = 1'b0;
    check("pp_setup_count", {29'd0, fifo_count}, 32'd1);
    repeat (869) tick();
    tx_valid = 1'b1;
    tx_data  = 8'h9E;
    check("pp_pre_count", {29'd0, fifo_count}, 32'd1);
    @(posedge clk);
    exp_q.push_back(8'h9E);
    #1 tx_valid = 1'b0;
    check("pp_post_count", {29'd0, fifo_count}, 32'd1);
    wait_idle(4000);
    check("pp_frames", 32'(starts.size()), 32'd3);
    if (starts.size() >= 2) check("pp_gap", 32'(starts[1] - starts[0]), 32'(FRAME));

    // Asynchronous reset during data bit 3 of 0xA5
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (390) tick();
    #3;
    aborted = 1'b1;
    resetn  = 1'b0;
    #1;
    check("abort_txd", {31'd0, TXD}, 32'd1);
    check("abort_count", {29'd0, fifo_count}, 32'd0);
    check("abort_ready", {31'd0, tx_ready}, 32'd1);
    check("abort_busy", {31'd0, tx_busy}, 32'd0);
    repeat (3) tick();
    resetn = 1'b1;
    n0 = 0;
    repeat (1200) begin
      tick();
      if (TXD !== 1'b1) n0++;
    end
    check("abort_quiet", 32'(n0), 32'd0);
    check("abort_idle_busy", {31'd0, tx_busy}, 32'd0);

    // Loopback pair
    tx_valid = 1'b1;
    tx_data  = 8'h3F;
    @(posedge clk);
    exp_q.push_back(8'h3F);
    #1 tx_data = 8'h55;
    @(posedge clk);
    exp_q.push_back(8'h55);
    #1 tx_valid = 1'b0;
    wait_idle(4000);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
